// File: rtl/shared_reg_pkg.sv
// shared_reg_pkg: FSM state type and index-width helper
// shared by the shared-register arbiter and its picker.
package shared_reg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: rotating-base priority encoder. req/base in,
// one-hot winner, its index and any-winner flag out.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int          k;
    logic [IW-1:0] ki;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = 0;
    ki     = '0;
    for (int i = 0; i < N; i++) begin
      k  = (int'(base) + i) % N;
      ki = IW'(k);
      if (!any && req[ki]) begin
        any        = 1'b1;
        onehot[ki] = 1'b1;
        idx        = ki;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: one WIDTH-bit register shared by NREQ writers.
// Ports: clk, Rst(async low), req/lock/wdata in; gnt, q, q_owner, q_valid, busy out.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [WIDTH-1:0]         q,
  output logic [idx_w(NREQ)-1:0]   q_owner,
  output logic                     q_valid,
  output logic                     busy
);

  localparam int IW = idx_w(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MAX_H = HW'(MAX_HOLD);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [IW-1:0] LAST  = IW'(NREQ - 1);
  localparam logic [IW-1:0] I_ONE = IW'(1);
  // A single-cycle hold is no hold at all.
  localparam bit LOCK_EN = (MAX_HOLD > 1);

  state_t          state, state_n;
  logic [IW-1:0]   owner, owner_n;
  logic [IW-1:0]   rr_ptr, rr_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [NREQ-1:0] gnt_c;
  logic [IW-1:0]   sel;
  logic            wr;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .base   (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_n = state;
    owner_n = owner;
    hold_n  = hold_cnt;
    rr_n    = rr_ptr;
    gnt_c   = '0;
    sel     = pick_idx;
    wr      = 1'b0;
    if (state == OWNED && req[owner]
        && hold_cnt < MAX_H) begin
      gnt_c[owner] = 1'b1;
      sel          = owner;
      wr           = 1'b1;
      hold_n       = hold_cnt + H_ONE;
      state_n      = (lock[owner] && (hold_cnt + H_ONE) < MAX_H)
                     ? OWNED : IDLE;
    end else if (pick_any) begin
      // Owner dropped req (or no burst): plain round-robin,
      // and the new winner may start its own burst.
      gnt_c = pick_oh;
      wr    = 1'b1;
      if (LOCK_EN && lock[pick_idx]) begin
        state_n = OWNED;
        owner_n = pick_idx;
        hold_n  = H_ONE;
      end else begin
        state_n = IDLE;
      end
    end else begin
      state_n = IDLE;
    end
    if (wr) rr_n = (sel == LAST) ? '0 : sel + I_ONE;
  end

  assign gnt  = Rst ? gnt_c : '0;
  assign busy = (state == OWNED);

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      q        <= '0;
      q_owner  <= '0;
      q_valid  <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_ptr   <= rr_n;
      hold_cnt <= hold_n;
      if (wr) begin
        q       <= wdata[int'(sel)*WIDTH +: WIDTH];
        q_owner <= sel;
        q_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed vectors into a scoreboard queue,
// checked by an independent monitor once per cycle.
module tb_shared_reg_arbiter;

  logic        clk;
  logic        Rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  q_owner;
  logic        q_valid;
  logic        busy;

  shared_reg_arbiter #(
    .NREQ     (4),
    .WIDTH    (8),
    .MAX_HOLD (4)
  ) dut (
    .clk     (clk),
    .Rst     (Rst),
    .req     (req),
    .lock    (lock),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .q_owner (q_owner),
    .q_valid (q_valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       id;
    bit       pulse;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [7:0] q;
    logic [1:0] own;
    logic       valid;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;
  int   cur = -1;

  task automatic add(input bit p, input logic [3:0] r,
                     input logic [3:0] l, input logic [3:0] g,
                     input logic [7:0] eq, input logic [1:0] eo,
                     input logic ev, input logic eb);
    vec_t v;
    v.id = vecs.size();
    v.pulse = p; v.req = r; v.lock = l; v.gnt = g;
    v.q = eq; v.own = eo; v.valid = ev; v.busy = eb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", n, cur, act, exp);
    end
  endtask

  // wdata_i = 8'h10 + i throughout
  initial begin
    wdata = 32'h1312_1110;
    req = '0;
    lock = '0;
    Rst = 1'b1;
    #1 Rst = 1'b0;
    // reset held with all requesting, then first grant to 0
    add(1, 4'b1111, 4'b0000, 4'b0000, 8'h00, 2'd0, 0, 0);
    // round robin
    add(0, 4'b1111, 4'b0000, 4'b0010, 8'h10, 2'd0, 1, 0);
    add(0, 4'b1111, 4'b0000, 4'b0100, 8'h11, 2'd1, 1, 0);
    add(0, 4'b1111, 4'b0000, 4'b1000, 8'h12, 2'd2, 1, 0);
    add(0, 4'b1111, 4'b0000, 4'b0001, 8'h13, 2'd3, 1, 0);
    add(0, 4'b1111, 4'b0000, 4'b0010, 8'h10, 2'd0, 1, 0);
    add(0, 4'b1111, 4'b0000, 4'b0100, 8'h11, 2'd1, 1, 0);
    add(0, 4'b1111, 4'b0000, 4'b1000, 8'h12, 2'd2, 1, 0);
    // lock burst of 4, then requester 1
    add(0, 4'b0011, 4'b0001, 4'b0001, 8'h13, 2'd3, 1, 0);
    add(0, 4'b0011, 4'b0001, 4'b0001, 8'h10, 2'd0, 1, 1);
    add(0, 4'b0011, 4'b0001, 4'b0001, 8'h10, 2'd0, 1, 1);
    add(0, 4'b0011, 4'b0001, 4'b0001, 8'h10, 2'd0, 1, 1);
    add(0, 4'b0011, 4'b0001, 4'b0010, 8'h10, 2'd0, 1, 0);
    // early release to requester 2
    add(0, 4'b0001, 4'b0001, 4'b0001, 8'h11, 2'd1, 1, 0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 8'h10, 2'd0, 1, 1);
    add(0, 4'b0100, 4'b0000, 4'b0100, 8'h10, 2'd0, 1, 1);
    // wrap 3 -> 0
    add(0, 4'b1001, 4'b0000, 4'b1000, 8'h12, 2'd2, 1, 0);
    add(0, 4'b1001, 4'b0000, 4'b0001, 8'h13, 2'd3, 1, 0);
    // async reset in burst cycle 2
    add(0, 4'b0001, 4'b0001, 4'b0001, 8'h10, 2'd0, 1, 0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 8'h10, 2'd0, 1, 1);
    add(1, 4'b1111, 4'b0000, 4'b0000, 8'h00, 2'd0, 0, 0);
    add(0, 4'b1111, 4'b0000, 4'b0010, 8'h10, 2'd0, 1, 0);
    // expiry with owner alone: new burst, then drop
    add(0, 4'b0001, 4'b0001, 4'b0001, 8'h11, 2'd1, 1, 0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 8'h10, 2'd0, 1, 1);
    add(0, 4'b0001, 4'b0001, 4'b0001, 8'h10, 2'd0, 1, 1);
    add(0, 4'b0001, 4'b0001, 4'b0001, 8'h10, 2'd0, 1, 1);
    add(0, 4'b0001, 4'b0001, 4'b0001, 8'h10, 2'd0, 1, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 8'h10, 2'd0, 1, 1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 8'h10, 2'd0, 1, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      #1;
      req  = vecs[i].req;
      lock = vecs[i].lock;
      Rst  = vecs[i].pulse ? 1'b0 : 1'b1;
      sb.push_back(vecs[i]);
      if (vecs[i].pulse) begin
        #3 Rst = 1'b1;
      end
    end
    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
  end

  initial begin
    vec_t e;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cur = e.id;
        chk("gnt", 32'(gnt), 32'(e.gnt));
        chk("q", 32'(q), 32'(e.q));
        chk("q_owner", 32'(q_owner), 32'(e.own));
        chk("q_valid", 32'(q_valid), 32'(e.valid));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      end
      if (done) break;
    end
    cur = -1;
    chk("timeout", 32'(done), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
